// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard frame receiver with prefix folding and event FIFO
//
// Purpose: synchronises and deglitches the PS/2 clock/data pins, deserialises
// 11-bit frames, checks start/parity/stop and an in-frame timeout, folds E0/F0
// prefixes into ext/rel flags and queues {code, ext, rel} events in a small FIFO.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ps2clk, ps2data   raw asynchronous PS/2 pins
//   code[7:0]         scancode at FIFO head
//   code_ext          head event was preceded by E0
//   code_rel          head event was preceded by F0
//   code_valid        FIFO non-empty, head fields valid
//   code_ack          pop head (ignored while code_valid=0)
//   frame_err         one-cycle pulse on start/parity/stop/timeout error
//   overflow          sticky: an event was dropped on a full FIFO
//   clr_overflow      clears overflow (a same-cycle set wins)
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 7000,
  parameter int FIFO_AW        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_rel,
  output logic       code_valid,
  input  logic       code_ack,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int FCW   = $clog2(FILTER_LEN + 1);
  localparam int TCW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;
  logic           s_clk, s_dat;

  assign s_clk = clk_sync_q[1];
  assign s_dat = dat_sync_q[1];

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (s_clk != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = s_clk;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2clk};
      dat_sync_q <= {dat_sync_q[0], ps2data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // ---------------- frame FSM ----------------
  state_t         state_q, state_d;
  logic [7:0]     shift_q;
  logic [2:0]     bitcnt_q;
  logic           par_q;
  logic [TCW-1:0] to_cnt_q;
  logic           timeout, good;
  logic           shift_en, par_en, accept, err;

  assign timeout = (state_q != IDLE) && (to_cnt_q == TCW'(TIMEOUT_CYCLES));
  assign good    = s_dat && (^{shift_q, par_q});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!s_dat) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    accept   = 1'b0;
    err      = timeout;
    if (fall && !timeout) begin
      case (state_q)
        IDLE:    err      = s_dat;
        DATA:    shift_en = 1'b1;
        PARITY:  par_en   = 1'b1;
        default: begin
          accept = good;
          err    = !good;
        end
      endcase
    end
  end

  // ---------------- datapath and prefix folding ----------------
  logic acc_q, ext_pend_q, rel_pend_q, frame_err_q;
  logic push;

  assign push = acc_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= '0;
      bitcnt_q    <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      acc_q       <= 1'b0;
      frame_err_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
    end else begin
      if (state_q == IDLE || fall || timeout) to_cnt_q <= '0;
      else                                    to_cnt_q <= to_cnt_q + 1'b1;
      if (state_q == IDLE) bitcnt_q <= '0;
      if (shift_en) begin
        shift_q  <= {s_dat, shift_q[7:1]};
        bitcnt_q <= bitcnt_q + 1'b1;
      end
      if (par_en) par_q <= s_dat;
      acc_q       <= accept;
      frame_err_q <= err;
      // shift_q still holds the accepted byte while acc_q is high.
      if (err || push) begin
        ext_pend_q <= 1'b0;
        rel_pend_q <= 1'b0;
      end else if (acc_q) begin
        if (shift_q == 8'hE0) ext_pend_q <= 1'b1;
        if (shift_q == 8'hF0) rel_pend_q <= 1'b1;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW:0]   wptr_q, rptr_q, wptr_d, rptr_d;
  logic [9:0]         head_q, head_d, push_data;
  logic               valid_q, ovf_q, full, pop, push_ok;

  assign push_data = {shift_q, ext_pend_q, rel_pend_q};
  assign full      = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop       = code_ack && valid_q;
  // A pop on a full FIFO frees the slot before the push lands.
  assign push_ok   = push && (!full || pop);
  assign rptr_d    = rptr_q + (FIFO_AW + 1)'(pop);
  assign wptr_d    = wptr_q + (FIFO_AW + 1)'(push_ok);

  // Bypass when the entry being written becomes the new head.
  always_comb begin
    head_d = mem[rptr_d[FIFO_AW-1:0]];
    if (push_ok && (rptr_d == wptr_q)) head_d = push_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[FIFO_AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      head_q  <= head_d;
      valid_q <= (wptr_d != rptr_d);
      if (push && !push_ok) ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign code       = head_q[9:2];
  assign code_ext   = head_q[1];
  assign code_rel   = head_q[0];
  assign code_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = ovf_q;

endmodule
